// File: rtl/tile_pkg.sv
// Shared screen constants, slot state type and helpers for the tile lane engine.
package tile_pkg;

    localparam int unsigned Y_MAX_DEF  = 479;
    localparam int unsigned LANE_W_DEF = 160;
    localparam int unsigned TILE_S_DEF = 75;
    localparam int unsigned HIT_LO_DEF = 320;
    localparam int unsigned STEP_BASE  = 3;

    // Screen coordinates are 10 bits; step and bottom/window sums use one
    // extra bit so nothing is truncated before the compare.
    localparam int unsigned COORD_W = 10;
    localparam int unsigned STEP_W  = 11;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic               active;
        logic [COORD_W-1:0] y;
    } tile_slot_t;

    // What one slot does on the coming edge.
    typedef enum logic [1:0] {
        SLOT_HOLD,
        SLOT_SPAWN,
        SLOT_MOVE,
        SLOT_CLEAR
    } slot_op_e;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/tile_slot.sv
// One tile slot: position register, fall step, bottom detect and the
// kill > bottom > move priority. Spawn only lands in a slot that is free
// before the edge, so it never competes with the active-slot actions.
module tile_slot
    import tile_pkg::*;
#(
    parameter int unsigned TILE_S = TILE_S_DEF,
    parameter int unsigned Y_MAX  = Y_MAX_DEF
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  logic [STEP_W-1:0] step,
    input  logic              spawn,
    input  logic              kill_sel,
    output tile_slot_t        slot,
    output logic              missed
);

    slot_op_e          op;
    logic [STEP_W-1:0] y_wide;
    logic [STEP_W-1:0] y_next;
    logic              bottom;

    // Decide this slot's action and its would-be next position.
    always_comb begin
        y_wide = STEP_W'(slot.y);
        y_next = y_wide + step;
        bottom = slot.active && ((y_wide + STEP_W'(TILE_S)) >= STEP_W'(Y_MAX));
        op     = SLOT_HOLD;
        if (slot.active) begin
            if (kill_sel || bottom) begin
                op = SLOT_CLEAR;
            end else begin
                op = SLOT_MOVE;
            end
        end else if (spawn) begin
            op = SLOT_SPAWN;
        end
        // A kill on the bottom edge counts as a hit, not a miss.
        missed = bottom && !kill_sel;
    end

    // Slot state register; cleared tiles keep their last Y.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot <= '0;
        end else begin
            case (op)
                SLOT_SPAWN: begin
                    slot.active <= 1'b1;
                    slot.y      <= '0;
                end
                SLOT_MOVE: begin
                    // A moving tile is above the bottom threshold, so the
                    // carry bit stays clear; clamp rather than wrap if not.
                    slot.y <= y_next[STEP_W-1] ? '1 : y_next[COORD_W-1:0];
                end
                SLOT_CLEAR: begin
                    slot.active <= 1'b0;
                end
                default: begin
                    slot <= slot;
                end
            endcase
        end
    end

endmodule

// File: rtl/tile_lane_engine.sv
// Falling-tile lane engine: LANES x SLOTS tile slots with per-lane spawn
// allocation, kill target selection, miss detection and event counters.
// Optional build macro TILE_HIT_WINDOW_EN restricts kills to tiles whose
// lower edge has reached HIT_LO.
module tile_lane_engine
    import tile_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned TILE_S = TILE_S_DEF,
    parameter int unsigned Y_MAX  = Y_MAX_DEF,
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned HIT_LO = HIT_LO_DEF
) (
    input  logic                             frame_clk,
    input  logic                             Reset_n,
    input  logic                             newNote,
    input  logic [$clog2(LANES)-1:0]         note_lane,
    input  logic                             kill,
    input  logic [$clog2(LANES)-1:0]         kill_lane,
    input  logic [3:0]                       speed,
    output logic [LANES*SLOTS*COORD_W-1:0]   TileY,
    output logic [LANES*SLOTS-1:0]           TileAct,
    output logic [LANES*COORD_W-1:0]         TileX,
    output logic [COORD_W-1:0]               TileS,
    output logic                             hit,
    output logic                             miss,
    output logic                             overflow,
    output logic [CNT_W-1:0]                 hit_cnt,
    output logic [CNT_W-1:0]                 miss_cnt
);

    localparam int unsigned N     = LANES * SLOTS;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef TILE_HIT_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
`else
    localparam bit WINDOW_EN = 1'b0;
`endif

    logic [STEP_W-1:0]  step;
    tile_slot_t         slots [N];
    logic [N-1:0]       spawn_sel;
    logic [N-1:0]       kill_sel;
    logic [N-1:0]       missed;
    logic [N-1:0]       eligible;
    logic               spawn_drop;
    logic               kill_found;
    logic [COORD_W-1:0] best_y;
    logic [IDX_W-1:0]   best_idx;
    logic [CNT_W-1:0]   miss_count;

    assign step = STEP_W'(STEP_BASE) + STEP_W'(speed);

    // Kill eligibility: any active tile, or only tiles inside the hit window.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = slots[i].active &&
                          (!WINDOW_EN ||
                           ((STEP_W'(slots[i].y) + STEP_W'(TILE_S)) >= STEP_W'(HIT_LO)));
        end
    end

    // Spawn allocator: lowest-index slot of note_lane that is free before the edge.
    always_comb begin
        spawn_sel  = '0;
        spawn_drop = 1'b0;
        if (newNote) begin
            spawn_drop = 1'b1;
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned s = 0; s < SLOTS; s++) begin
                    if ((32'(note_lane) == l) && spawn_drop && !slots[l*SLOTS+s].active) begin
                        spawn_sel[l*SLOTS+s] = 1'b1;
                        spawn_drop           = 1'b0;
                    end
                end
            end
        end
    end

    // Kill selector: eligible tile of kill_lane with the largest Y; the
    // strict compare keeps the lowest slot index on ties.
    always_comb begin
        kill_sel   = '0;
        kill_found = 1'b0;
        best_y     = '0;
        best_idx   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if ((32'(kill_lane) == l) && eligible[l*SLOTS+s] &&
                    (!kill_found || (slots[l*SLOTS+s].y > best_y))) begin
                    kill_found = 1'b1;
                    best_y     = slots[l*SLOTS+s].y;
                    best_idx   = IDX_W'(l*SLOTS+s);
                end
            end
        end
        if (kill && kill_found) begin
            kill_sel[best_idx] = 1'b1;
        end
    end

    // Number of tiles reaching the bottom on this edge.
    always_comb begin
        miss_count = '0;
        for (int unsigned i = 0; i < N; i++) begin
            miss_count = miss_count + CNT_W'(missed[i]);
        end
    end

    // Event pulses, sticky overflow and saturating counters.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit      <= 1'b0;
            miss     <= 1'b0;
            overflow <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            hit      <= kill && kill_found;
            miss     <= |missed;
            miss_cnt <= sat_add(miss_cnt, miss_count);
            if (spawn_drop) begin
                overflow <= 1'b1;
            end
            if (kill && kill_found) begin
                hit_cnt <= sat_add(hit_cnt, CNT_W'(1));
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_slot
        tile_slot #(
            .TILE_S (TILE_S),
            .Y_MAX  (Y_MAX)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .step      (step),
            .spawn     (spawn_sel[i]),
            .kill_sel  (kill_sel[i]),
            .slot      (slots[i]),
            .missed    (missed[i])
        );
        assign TileY[i*COORD_W +: COORD_W] = slots[i].y;
        assign TileAct[i]                  = slots[i].active;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign TileX[l*COORD_W +: COORD_W] = COORD_W'(l*LANE_W + LANE_W/2);
    end

    assign TileS = COORD_W'(TILE_S);

endmodule

// File: tb/tb_tile_lane_engine.sv
// Self-checking bench for tile_lane_engine against a per-edge array model.
module tb_tile_lane_engine;

    localparam int LANES  = 4;
    localparam int SLOTS  = 4;
    localparam int N      = LANES * SLOTS;
    localparam int TILE_S = 75;
    localparam int Y_MAX  = 479;
    localparam int HIT_LO = 320;
`ifdef TILE_HIT_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    logic         frame_clk = 1'b0;
    logic         Reset_n   = 1'b1;
    logic         newNote   = 1'b0;
    logic [1:0]   note_lane = '0;
    logic         kill      = 1'b0;
    logic [1:0]   kill_lane = '0;
    logic [3:0]   speed     = '0;
    logic [159:0] TileY;
    logic [15:0]  TileAct;
    logic [39:0]  TileX;
    logic [9:0]   TileS;
    logic         hit, miss, overflow;
    logic [15:0]  hit_cnt, miss_cnt;
    logic [210:0] dut_vec;

    int checks   = 0;
    int failures = 0;

    int m_act [N];
    int m_y   [N];
    int m_hit, m_miss, m_ovf, m_hcnt, m_mcnt;

    always #5 frame_clk = ~frame_clk;

    tile_lane_engine #(
        .LANES  (LANES),
        .SLOTS  (SLOTS),
        .TILE_S (TILE_S),
        .Y_MAX  (Y_MAX),
        .LANE_W (160),
        .HIT_LO (HIT_LO)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .newNote   (newNote),
        .note_lane (note_lane),
        .kill      (kill),
        .kill_lane (kill_lane),
        .speed     (speed),
        .TileY     (TileY),
        .TileAct   (TileAct),
        .TileX     (TileX),
        .TileS     (TileS),
        .hit       (hit),
        .miss      (miss),
        .overflow  (overflow),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    assign dut_vec = {TileAct, TileY, hit, miss, overflow, hit_cnt, miss_cnt};

    function automatic logic [210:0] exp_vec();
        logic [15:0]  a;
        logic [159:0] y;
        for (int i = 0; i < N; i++) begin
            a[i]          = (m_act[i] != 0);
            y[i*10 +: 10] = 10'(m_y[i]);
        end
        return {a, y, m_hit[0], m_miss[0], m_ovf[0], 16'(m_hcnt), 16'(m_mcnt)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0;
            m_y[i]   = 0;
        end
        m_hit = 0; m_miss = 0; m_ovf = 0; m_hcnt = 0; m_mcnt = 0;
    endtask

    // Reference behaviour of one frame edge, from the pre-edge model state.
    task automatic model_edge(input bit nn, input int nl, input bit k, input int kl, input int sp);
        int step, best, free, misses;
        step = 3 + sp; best = -1; free = -1; misses = 0;
        if (k) begin
            for (int s = 0; s < SLOTS; s++) begin
                int i;
                i = kl * SLOTS + s;
                if (m_act[i] != 0 && (!WIN || m_y[i] + TILE_S >= HIT_LO) &&
                    (best < 0 || m_y[i] > m_y[best])) best = i;
            end
        end
        if (nn) begin
            for (int s = 0; s < SLOTS; s++) begin
                int i;
                i = nl * SLOTS + s;
                if (m_act[i] == 0 && free < 0) free = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) begin
                if (i == best) m_act[i] = 0;
                else if (m_y[i] + TILE_S >= Y_MAX) begin
                    m_act[i] = 0;
                    misses++;
                end else m_y[i] = m_y[i] + step;
            end
        end
        if (free >= 0) begin
            m_act[free] = 1;
            m_y[free]   = 0;
        end else if (nn) m_ovf = 1;
        m_hit  = (best >= 0);
        m_miss = (misses > 0);
        if (best >= 0) m_hcnt = (m_hcnt + 1 > 65535) ? 65535 : m_hcnt + 1;
        m_mcnt = (m_mcnt + misses > 65535) ? 65535 : m_mcnt + misses;
    endtask

    task automatic drive_edge(input bit nn, input int nl, input bit k, input int kl, input int sp);
        @(negedge frame_clk);
        newNote   = nn;
        note_lane = 2'(nl);
        kill      = k;
        kill_lane = 2'(kl);
        speed     = 4'(sp);
        model_edge(nn, nl, k, kl, sp);
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        newNote = 1'b0; kill = 1'b0; speed = '0;
        Reset_n = 1'b0;
        model_reset();
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [39:0] exp_x;
        #1;
        Reset_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
        end
        for (int l = 0; l < LANES; l++) exp_x[l*10 +: 10] = 10'(l * 160 + 80);
        checks++;
        if (TileX !== exp_x || TileS !== 10'd75) begin
            failures++;
            $display("FAIL const_xs got=%h/%0d exp=%h/75", TileX, TileS, exp_x);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_spawn_fall();
        int edges;
        bit seen;
        do_reset();
        drive_edge(1, 2, 0, 0, 0);
        checks++;
        if (TileAct !== 16'h0100 || TileY[80 +: 10] !== 10'd0) begin
            failures++;
            $display("FAIL spawn_slot8 got act=%h y=%0d exp act=0100 y=0", TileAct, TileY[80 +: 10]);
        end
        edges = 0; seen = 0;
        while (!seen && edges < 200) begin
            drive_edge(0, 0, 0, 0, 0);
            edges++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fall_track edge=%0d got=%h exp=%h", edges, dut_vec, exp_vec());
            end
            if (miss === 1'b1) seen = 1;
        end
        checks++;
        if (edges != 136 || TileAct !== 16'h0 || miss_cnt !== 16'd1) begin
            failures++;
            $display("FAIL miss_edge got edge=%0d act=%h cnt=%0d exp edge=136 act=0 cnt=1", edges, TileAct, miss_cnt);
        end
        drive_edge(0, 0, 0, 0, 0);
        checks++;
        if (miss !== 1'b0) begin
            failures++;
            $display("FAIL miss_pulse got=%b exp=0", miss);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_edge(1, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL overflow_track spawn=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL overflow_early got=%b exp=0", overflow);
                end
            end
        end
        checks++;
        if (TileAct[3:0] !== 4'hF || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set got act=%h ovf=%b exp act=f ovf=1", TileAct[3:0], overflow);
        end
    endtask

    task automatic test_kill_select();
        do_reset();
        drive_edge(1, 1, 0, 0, 0);
        repeat (49) drive_edge(0, 0, 0, 0, 0);
        drive_edge(1, 1, 0, 0, 0);
        repeat (50) drive_edge(0, 0, 0, 0, 0);
        checks++;
        if (TileY[40 +: 10] !== 10'd300 || TileY[50 +: 10] !== 10'd150) begin
            failures++;
            $display("FAIL kill_setup got y4=%0d y5=%0d exp 300/150", TileY[40 +: 10], TileY[50 +: 10]);
        end
        drive_edge(0, 0, 1, 1, 0);
        checks++;
        if (TileAct[5:4] !== 2'b10 || TileY[50 +: 10] !== 10'd153 || hit !== 1'b1 || hit_cnt !== 16'd1) begin
            failures++;
            $display("FAIL kill_largest got act=%b y5=%0d hit=%b cnt=%0d exp act=10 y5=153 hit=1 cnt=1",
                     TileAct[5:4], TileY[50 +: 10], hit, hit_cnt);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL kill_model got=%h exp=%h", dut_vec, exp_vec());
        end
        drive_edge(0, 0, 0, 0, 0);
        checks++;
        if (hit !== 1'b0 || hit_cnt !== 16'd1) begin
            failures++;
            $display("FAIL hit_pulse got hit=%b cnt=%0d exp hit=0 cnt=1", hit, hit_cnt);
        end
    endtask

    task automatic test_window();
        do_reset();
        drive_edge(1, 2, 0, 0, 0);
        repeat (10) drive_edge(0, 0, 0, 0, 7);
        drive_edge(0, 0, 1, 2, 0);
        checks++;
        if (hit !== !WIN || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL window_y100 got hit=%b vec=%h exp hit=%b vec=%h", hit, dut_vec, !WIN, exp_vec());
        end
        repeat (49) drive_edge(0, 0, 0, 0, 0);
        drive_edge(0, 0, 1, 2, 0);
        checks++;
        if (hit !== WIN || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL window_y250 got hit=%b vec=%h exp hit=%b vec=%h", hit, dut_vec, WIN, exp_vec());
        end
    endtask

    task automatic test_kill_spawn_full();
        do_reset();
        repeat (4) drive_edge(1, 3, 0, 0, 0);
        drive_edge(1, 3, 1, 3, 0);
        checks++;
        if (TileAct[15:12] !== 4'b1110 || hit !== 1'b1 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL kill_spawn_same got act=%b hit=%b ovf=%b exp act=1110 hit=1 ovf=1",
                     TileAct[15:12], hit, overflow);
        end
        drive_edge(1, 3, 0, 0, 0);
        checks++;
        if (TileAct[15:12] !== 4'hF || TileY[120 +: 10] !== 10'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL reuse_freed got act=%b y12=%0d exp act=1111 y12=0", TileAct[15:12], TileY[120 +: 10]);
        end
    endtask

    task automatic test_multi_miss();
        int edges;
        do_reset();
        drive_edge(1, 0, 0, 0, 0);
        drive_edge(1, 1, 0, 0, 0);
        edges = 0;
        while (miss !== 1'b1 && edges < 100) begin
            drive_edge(0, 0, 0, 0, 15);
            edges++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL multi_track edge=%0d got=%h exp=%h", edges, dut_vec, exp_vec());
            end
        end
        checks++;
        if (miss !== 1'b1 || miss_cnt !== 16'd2 || TileAct !== 16'h0) begin
            failures++;
            $display("FAIL multi_miss got miss=%b cnt=%0d act=%h exp miss=1 cnt=2 act=0", miss, miss_cnt, TileAct);
        end
    endtask

    task automatic test_random();
        bit nn, k;
        do_reset();
        for (int e = 0; e < 400; e++) begin
            nn = ($urandom_range(0, 9) < 4);
            k  = ($urandom_range(0, 9) < 3);
            drive_edge(nn, $urandom_range(0, 3), k, $urandom_range(0, 3), $urandom_range(0, 15));
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random edge=%0d got=%h exp=%h", e, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        realtime t0;
        drive_edge(1, 0, 0, 0, 0);
        drive_edge(1, 1, 0, 0, 0);
        @(negedge frame_clk);
        newNote = 1'b0; kill = 1'b0; speed = '0;
        #2;
        t0 = $realtime;
        Reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== exp_vec() || ($realtime - t0) > 2.0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec, exp_vec());
        end
        Reset_n = 1'b1;
        drive_edge(1, 0, 0, 0, 0);
        checks++;
        if (TileAct !== 16'h0001 || TileY[9:0] !== 10'd0 || dut_vec !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset_spawn got act=%h y0=%0d exp act=0001 y0=0", TileAct, TileY[9:0]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_spawn_fall();
        test_overflow();
        test_kill_select();
        test_window();
        test_kill_spawn_full();
        test_multi_miss();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
